serdes_lane: RTL
================

// Module: serdes_lane
// PURPOSE
// - Parametrised serialiser/deserialiser lane. Next generation of the 8-bit tt_um SERDES:
//   width-generic, framed with a start bit, ready/valid on both parallel sides.
// - Adds bit-order select, internal loopback and a sticky RX overrun flag.
// - Sits between the tt_um top-level pin mapping and the parallel data logic.
//   Used alone or instanced per lane.
// PARAMETERS
// - DATA_W     8  parallel word width in bits; legal range 2..32.
// - LSB_FIRST  1  1: bit0 is serialised first; 0: bit DATA_W-1 is serialised first.
// - CNT_W      derived localparam, $clog2(DATA_W+1); not overridable.
// PORTS
// - clk        in   1       single clock; all state updates on its rising edge
// - rst        in   1       asynchronous, active-high reset
// - tx_data    in   DATA_W  word to serialise
// - tx_valid   in   1       tx_data is valid
// - tx_ready   out  1       lane accepts tx_data this cycle
// - ser_out    out  1       serial line out; registered; idle level 0
// - ser_in     in   1       serial line in (external)
// - loopback   in   1       1: RX samples ser_out internally; 0: RX samples ser_in
// - rx_data    out  DATA_W  received word; held stable while rx_valid=1
// - rx_valid   out  1       rx_data holds an unconsumed word
// - rx_ready   in   1       consumer takes rx_data
// - rx_ovr     out  1       sticky overrun flag
// - ovr_clr    in   1       synchronous clear of rx_ovr
// BEHAVIOUR
// - Reset (async assert, removal on clk): all outputs 0 except tx_ready=1.
//   TX=IDLE, RX=IDLE, counters 0.
//   Asserting rst mid-frame aborts the frame with no partial word delivered.
// - Frame on the line: one start bit (1), then DATA_W data bits. Line idle = 0. No stop bit.
// - TX FSM {TX_IDLE, TX_SHIFT}; tcnt counts data bits already driven.
//   - Accept when tx_valid & tx_ready: load the shift register, ser_out<=1 (start bit),
//     tcnt<=0, go to TX_SHIFT.
//   - In TX_SHIFT, each edge: ser_out<=next bit in LSB_FIRST order, tcnt++.
//   - tx_ready = (state==TX_IDLE) | (tcnt==DATA_W), so back-to-back frames are legal.
//     Period is DATA_W+1 cycles with no idle gap.
//   - At tcnt==DATA_W with no accept: ser_out<=0, go to TX_IDLE.
//   - tx_data is sampled only at accept; later changes have no effect.
// - RX FSM {RX_IDLE, RX_SHIFT}; rb = loopback ? ser_out : ser_in, sampled every edge.
//   - RX_IDLE & rb==1: go to RX_SHIFT, rcnt<=0 (start bit consumed).
//   - RX_SHIFT: shift rb in LSB_FIRST order, rcnt++.
//   - When the DATA_W-th bit is sampled, go to RX_IDLE; a start bit on the next edge is
//     recognised, so back-to-back reception is supported.
// - RX output register:
//   - On word completion with (!rx_valid | rx_ready): rx_data<=word, rx_valid<=1.
//   - On word completion with rx_valid & !rx_ready: the new word is dropped, rx_data is
//     unchanged, rx_ovr<=1.
//   - rx_ready with no completion: rx_valid<=0.
//   - ovr_clr coincident with a new overrun: set wins, rx_ovr stays 1.
// - Loopback latency: accept at edge A, rx_valid=1 after edge A+DATA_W+1.
// - ser_in stuck at 1 gives continuous all-ones words. No lockup in any input sequence.
// - A loopback toggle mid-frame corrupts only that word; the FSMs resynchronise on the
//   next start bit after RX_IDLE.
// STRUCTURE
// - Package serdes_pkg: tx_state_t and rx_state_t enums; START_BIT=1'b1, IDLE_LVL=1'b0.
// - Sub-module serdes_shreg (params W, LSB_FIRST; ports load, shift, d_in, par_in,
//   bit_out, par_out). Instanced twice: TX as PISO, RX as SIPO.
// - Top holds both FSMs, counters, loopback mux and the RX output/overrun register.
// TESTING (DATA_W=8, LSB_FIRST=1 unless noted)
// - Reset: assert rst mid-TX-frame -> ser_out=0, tx_ready=1, rx_valid=0, rx_ovr=0 immediately.
// - Loopback single word: loopback=1, tx 0xA5 -> ser_out 1,1,0,1,0,0,1,0,1;
//   rx_data=0xA5, rx_valid after 9 cycles.
// - Back-to-back: tx 0x01,0x80,0xFF with tx_valid held, rx_ready=1 -> 27-cycle burst,
//   no idle bits, three words received in order.
// - MSB-first: LSB_FIRST=0, tx 0x81 -> ser_out 1,1,0,0,0,0,0,0,1; loopback rx_data=0x81.
// - Overrun: rx_ready=0, two loopback words 0x3C,0xC3 -> rx_data=0x3C, rx_ovr=1;
//   ovr_clr -> rx_ovr=0.
// - External RX: loopback=0, drive ser_in 0,0,1 then bits of 0x5A -> rx_data=0x5A;
//   idle zeros before the start bit are ignored.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and line-level constants for the serialiser/deserialiser lane.
package serdes_pkg;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/serdes_shreg.sv
// Bidirectional-order shift register: parallel load for PISO use, serial
// shift-in for SIPO use. bit_out is the next bit to leave in the chosen order.
module serdes_shreg
  import serdes_pkg::*;
#(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic         d_in,
  input  logic [W-1:0] par_in,
  output logic         bit_out,
  output logic [W-1:0] par_out
);

  logic [W-1:0] sr;

  // Load a whole word or move one bit along in the configured order
  always_ff @(posedge clk) begin
    if (load) begin
      sr <= par_in;
    end else if (shift) begin
      if (LSB_FIRST) sr <= {d_in, sr[W-1:1]};
      else           sr <= {sr[W-2:0], d_in};
    end
  end

  assign bit_out = LSB_FIRST ? sr[0] : sr[W-1];
  assign par_out = sr;

endmodule

// File: rtl/serdes_lane.sv
// Framed serial lane: start bit followed by DATA_W data bits, ready/valid on
// both parallel sides, selectable bit order, internal loopback and a sticky
// receive overrun flag.
module serdes_lane
  import serdes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  input  logic              ser_in,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_ovr,
  input  logic              ovr_clr
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(DATA_W - 1);

  tx_state_t         tx_state;
  logic [CNT_W-1:0]  tcnt;
  logic              tx_accept;
  logic              tx_shift;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_par_unused;

  rx_state_t         rx_state;
  logic [CNT_W-1:0]  rcnt;
  logic              rb;
  logic              rx_shift;
  logic              rx_done;
  logic [DATA_W-1:0] rx_par;
  logic [DATA_W-1:0] rx_word;
  logic              rx_bit_unused;

  // The last data bit may overlap the next accept, so frames run back to back
  assign tx_ready  = (tx_state == TX_IDLE) | (tcnt == CNT_LAST);
  assign tx_accept = tx_valid & tx_ready;
  assign tx_shift  = (tx_state == TX_SHIFT) && (tcnt != CNT_LAST);

  serdes_shreg #(.W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_tx_sr (
    .clk     (clk),
    .load    (tx_accept),
    .shift   (tx_shift),
    .d_in    (IDLE_LVL),
    .par_in  (tx_data),
    .bit_out (tx_bit),
    .par_out (tx_par_unused)
  );

  // TX FSM: start bit on accept, then one data bit per cycle, registered line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tcnt     <= '0;
      ser_out  <= IDLE_LVL;
    end else if (tx_accept) begin
      tx_state <= TX_SHIFT;
      tcnt     <= '0;
      ser_out  <= START_BIT;
    end else begin
      case (tx_state)
        TX_SHIFT: begin
          if (tcnt == CNT_LAST) begin
            tx_state <= TX_IDLE;
            tcnt     <= '0;
            ser_out  <= IDLE_LVL;
          end else begin
            tcnt    <= tcnt + CNT_W'(1);
            ser_out <= tx_bit;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          ser_out  <= IDLE_LVL;
        end
      endcase
    end
  end

  // Loopback taps the registered line so RX sees exactly what leaves the pin
  assign rb       = loopback ? ser_out : ser_in;
  assign rx_shift = (rx_state == RX_SHIFT);
  assign rx_done  = rx_shift && (rcnt == CNT_PEN);

  serdes_shreg #(.W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_rx_sr (
    .clk     (clk),
    .load    (1'b0),
    .shift   (rx_shift),
    .d_in    (rb),
    .par_in  ({DATA_W{1'b0}}),
    .bit_out (rx_bit_unused),
    .par_out (rx_par)
  );

  // Completed word includes the bit being sampled on this edge
  assign rx_word = LSB_FIRST ? {rb, rx_par[DATA_W-1:1]}
                             : {rx_par[DATA_W-2:0], rb};

  // RX FSM: hunt for a start bit, then count DATA_W data bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rcnt     <= '0;
    end else begin
      case (rx_state)
        RX_SHIFT: begin
          if (rcnt == CNT_PEN) begin
            rx_state <= RX_IDLE;
            rcnt     <= '0;
          end else begin
            rcnt <= rcnt + CNT_W'(1);
          end
        end
        default: begin
          if (rb == START_BIT) begin
            rx_state <= RX_SHIFT;
            rcnt     <= '0;
          end
        end
      endcase
    end
  end

  // Output holding register with drop-newest overrun and set-wins sticky flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      if (rx_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
          if (ovr_clr) rx_ovr <= 1'b0;
        end else begin
          rx_ovr <= 1'b1;
        end
      end else begin
        if (rx_ready) rx_valid <= 1'b0;
        if (ovr_clr)  rx_ovr   <= 1'b0;
      end
    end
  end

endmodule
